instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage: owns the program counter, issues single-outstanding word requests to instruction memory over a req/gnt/rvalid handshake, and presents the fetched instruction, its PC and PC+4 to the IF/ID pipeline register. It sits directly upstream of that register. Stall and branch-redirect inputs come from the hazard unit and the execute stage. Invalid slots are filled with the canonical NOP so downstream sees bubbles.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  downstream hold; output registers must not change
- branch_taken_i  in  1  redirect request, single-cycle pulse
- branch_target_i  in  32  redirect PC
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  32  request word address (bits [1:0] always 0)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  32  response instruction word
- instr_o  out  32  fetched instruction, or NOP 32'h00000013
- pc_o  out  32  PC of instr_o
- pc_incr_o  out  32  pc_o + 4
- valid_o  out  1  instr_o holds a real fetched instruction

## Operation
- Registers: pc_q (next fetch address), fetch_pc_q (address of outstanding request), kill_q, hold buffer {instr, pc}, state, output registers.
- States: S_REQ, S_WAIT, S_HOLD.
- S_REQ: imem_req_o=1, imem_addr_o=pc_q. On gnt: fetch_pc_q<=pc_q, pc_q<=pc_q+4, go to S_WAIT. No gnt: stay; the address must stay stable unless a redirect occurs.
- S_WAIT: imem_req_o=0. On rvalid with kill_q=1: drop the data, clear kill_q, go to S_REQ. On rvalid with stall_i=0: load the output registers with {rdata, fetch_pc_q, fetch_pc_q+4}, set valid_o=1, go to S_REQ. On rvalid with stall_i=1: capture the data into the hold buffer, go to S_HOLD.
- S_HOLD: imem_req_o=0. On stall_i=0: load the output registers from the hold buffer, go to S_REQ.
- Redirect (branch_taken_i=1) overrides everything in any state:
  - pc_q<=branch_target_i.
  - Output registers become NOP with valid_o=0, even if stall_i=1.
  - S_REQ without gnt: the next cycle requests the target.
  - S_REQ with gnt in the same cycle: the old request is issued. Set kill_q and go to S_WAIT.
  - S_WAIT without rvalid: set kill_q and stay.
  - S_WAIT with rvalid in the same cycle: drop the data, go to S_REQ.
  - S_HOLD: discard the buffer, go to S_REQ.
- When no new instruction loads and stall_i=0: the output registers become NOP, pc_o/pc_incr_o hold, valid_o=0.
- Arithmetic: 32-bit, PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Only one request is ever outstanding. No new req is issued until its rvalid is consumed.

## Timing
- Reset values:
  - state=S_REQ, pc_q=RESET_PC, kill_q=0.
  - imem_req_o=0 while rst_n=0; asserted combinationally once rst_n=1.
  - imem_addr_o=RESET_PC.
  - instr_o=32'h00000013, pc_o=0, pc_incr_o=0, valid_o=0.
- Minimum latency with zero-wait memory (gnt in cycle N, rvalid in N+1): instr_o valid at N+2.
- Throughput: at most one instruction per 2 cycles.
- A redirect in cycle N puts the target on imem_addr_o in N+1 (or after the killed response returns).
- Reset mid-operation clears kill_q and abandons any outstanding response. Memory must not return rvalid for a request issued before reset.

## Configuration
- INSTR_FETCH_MISALIGN_CHECK_EN defined:
  - Adds output misalign_o (1 bit) and misalign_addr_o (32 bits).
  - A redirect with target[1:0]!=0 does not change pc_q or state.
  - misalign_o pulses high for exactly 1 cycle; misalign_addr_o is held with the target.
  - Outputs are still flushed to NOP.
- Not defined: the ports are absent, and target[1:0] is silently forced to 0.

## Structure
- Shared package riscv_pkg:
  - XLEN=32.
  - NOP_INSTR=32'h00000013.
  - The fetch state enum (S_REQ/S_WAIT/S_HOLD).
- One sub-module, instr_fetch_pcgen: holds pc_q, next-PC mux (hold / +4 / target) and the misalign check. The FSM, kill logic, hold buffer and output registers stay in instr_fetch.

## Test plan
- Reset release, zero-wait memory returning 32'h00500093 at 0 → instr_o=32'h00500093, pc_o=0, pc_incr_o=4, valid_o=1 two cycles after the first gnt; the next request address is 4.
- gnt withheld 3 cycles at PC 8 → imem_addr_o stays 8, imem_req_o stays high, outputs are NOP/valid_o=0.
- stall_i high when rvalid arrives with 32'h00A00113 at PC 4 → outputs unchanged. On stall_i low, the next cycle shows instr_o=32'h00A00113, pc_o=4.
- branch_taken_i to 32'h100 while in S_WAIT, then rvalid → the response is dropped, the next imem_addr_o is 32'h100, and no stale instruction reaches instr_o.
- Fetch at 32'hFFFF_FFFC → pc_incr_o=0, the next request address is 0.
- With INSTR_FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 → misalign_o is high for 1 cycle, misalign_addr_o=32'h102, pc_q is unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// Shared RV32 definitions for the fetch stage: word width, canonical NOP, fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// Instruction-memory req/gnt/rvalid bus; master is the fetch stage, slave is the memory.
interface instr_fetch_if;
  import riscv_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_pcgen.sv
`default_nettype none
// Program counter and next-PC select (hold / +4 / redirect target).
// Optional INSTR_FETCH_MISALIGN_CHECK_EN rejects misaligned redirect targets and reports them.
module instr_fetch_pcgen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            advance_i,
  input  wire logic            branch_taken_i,
  input  wire logic [XLEN-1:0] branch_target_i,
  output logic      [XLEN-1:0] pc_o,
  output logic                 redirect_o
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  ,
  output logic                 misalign_o,
  output logic      [XLEN-1:0] misalign_addr_o
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic            misalign_d, misalign_q;
  logic [XLEN-1:0] misalign_addr_q;

  assign misalign_d = branch_taken_i && (branch_target_i[1:0] != 2'b00);
  assign redirect_o = branch_taken_i && !misalign_d;

  // Address register keeps the last offending target after the pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q <= misalign_d;
      if (misalign_d) misalign_addr_q <= branch_target_i;
    end
  end

  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`else
  assign redirect_o = branch_taken_i;
`endif

  // A redirect wins over the +4 of a request granted in the same cycle.
  always_comb begin
    pc_d = pc_q;
    if (redirect_o)     pc_d = branch_target_i & ~(XLEN'(3));
    else if (advance_i) pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// Fetch stage: single-outstanding imem requests, kill/hold handling, registered IF/ID outputs.
// Optional INSTR_FETCH_MISALIGN_CHECK_EN adds misalign_o / misalign_addr_o.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            stall_i,
  input  wire logic            branch_taken_i,
  input  wire logic [XLEN-1:0] branch_target_i,
  instr_fetch_if.master        imem,
  output logic      [XLEN-1:0] instr_o,
  output logic      [XLEN-1:0] pc_o,
  output logic      [XLEN-1:0] pc_incr_o,
  output logic                 valid_o
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  ,
  output logic                 misalign_o,
  output logic      [XLEN-1:0] misalign_addr_o
`endif
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q, fetch_pc_q, hold_instr_q, hold_pc_q;
  logic            kill_q;
  logic [XLEN-1:0] instr_q, out_pc_q, out_pc_incr_q;
  logic            valid_q;

  logic            advance, redirect, load;
  logic [XLEN-1:0] load_instr, load_pc;

  assign advance = (state_q == S_REQ) && imem.imem_gnt_i;

  instr_fetch_pcgen #(.RESET_PC(RESET_PC)) u_pcgen (
    .clk             (clk),
    .rst_n           (rst_n),
    .advance_i       (advance),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_q),
    .redirect_o      (redirect)
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
`endif
  );

  assign imem.imem_req_o  = rst_n && (state_q == S_REQ);
  assign imem.imem_addr_o = pc_q;

  always_comb begin
    load       = 1'b0;
    load_instr = hold_instr_q;
    load_pc    = hold_pc_q;
    if (state_q == S_WAIT) begin
      load       = imem.imem_rvalid_i && !kill_q && !stall_i;
      load_instr = imem.imem_rdata_i;
      load_pc    = fetch_pc_q;
    end else if (state_q == S_HOLD) begin
      load = !stall_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= '0;
      kill_q        <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc_q     <= '0;
      instr_q       <= NOP_INSTR;
      out_pc_q      <= '0;
      out_pc_incr_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          // Redirect with a simultaneous grant: the old request still goes out and is killed.
          if (imem.imem_gnt_i) begin
            fetch_pc_q <= pc_q;
            kill_q     <= redirect;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid_i) begin
            kill_q <= 1'b0;
            if (kill_q || redirect || !stall_i) begin
              state_q <= S_REQ;
            end else begin
              hold_instr_q <= imem.imem_rdata_i;
              hold_pc_q    <= fetch_pc_q;
              state_q      <= S_HOLD;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || !stall_i) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      // Any redirect flushes the outputs, even under stall.
      if (branch_taken_i) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (load) begin
        instr_q       <= load_instr;
        out_pc_q      <= load_pc;
        out_pc_incr_q <= load_pc + XLEN'(4);
        valid_q       <= 1'b1;
      end else if (!stall_i) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = out_pc_q;
  assign pc_incr_o = out_pc_incr_q;
  assign valid_o   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Scoreboard bench for instr_fetch: modelled memory, stall and redirect traffic, directed then random.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] instr_o, pc_o, pc_incr_o;
  logic        valid_o;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  instr_fetch_if imem ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem            (imem),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .pc_incr_o       (pc_incr_o),
    .valid_o         (valid_o)
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  // Reference model state
  logic [63:0] sb_q[$];
  logic        pending = 0, pend_killed = 0, held = 0, load_next = 0;
  logic        st_prev = 0, br_prev = 0, rnd_on = 0;
  logic [31:0] pend_addr = 0, exp_pc = 0;
  int          rv_cnt = 0, gnt_cnt = 0, rv_delay = 0;
  logic [31:0] m_instr = NOP_INSTR, m_pc = 0, m_incr = 0;
  logic        m_valid = 0;
  logic        mis_exp = 0;
  logic [31:0] mis_addr_exp = 0;

  // One clock: check outputs of the edge just taken, then drive inputs for the next edge.
  task automatic cycle(input logic br, input logic [31:0] tgt, input logic st);
    logic        br_eff, req_now;
    logic [31:0] rd;
    @(negedge clk);
    if (br_prev) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
    end else if (load_next) begin
      {m_instr, m_pc} = sb_q.pop_front();
      m_incr  = m_pc + 32'd4;
      m_valid = 1'b1;
    end else if (!st_prev) begin
      m_instr = NOP_INSTR;
      m_valid = 1'b0;
    end
    check_eq("instr_o", instr_o, m_instr);
    check_eq("pc_o", pc_o, m_pc);
    check_eq("pc_incr_o", pc_incr_o, m_incr);
    check_eq("valid_o", {31'b0, valid_o}, {31'b0, m_valid});
    req_now = !pending && !held;
    check_eq("imem_req_o", {31'b0, imem.imem_req_o}, {31'b0, req_now});
    if (req_now) check_eq("imem_addr_o", imem.imem_addr_o, exp_pc);
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    check_eq("misalign_o", {31'b0, misalign_o}, {31'b0, mis_exp});
    check_eq("misalign_addr_o", misalign_addr_o, mis_addr_exp);
    br_eff  = br && (tgt[1:0] == 2'b00);
    mis_exp = br && !br_eff;
    if (mis_exp) mis_addr_exp = tgt;
`else
    br_eff = br;
`endif
    load_next = 1'b0;
    if (held) begin
      if (br_eff || (br && !st)) void'(sb_q.pop_back());
      else if (!st)              load_next = 1'b1;
      if (br_eff || !st) held = 1'b0;
    end
    imem.imem_gnt_i    = 1'b0;
    imem.imem_rvalid_i = 1'b0;
    rd = 32'h0;
    if (pending) begin
      if (rv_cnt == 0) begin
        rd = mem_word(pend_addr);
        imem.imem_rvalid_i = 1'b1;
        pending = 1'b0;
        if (!(pend_killed || br_eff || (br && !st))) begin
          sb_q.push_back({rd, pend_addr});
          if (st) held = 1'b1;
          else    load_next = 1'b1;
        end
        pend_killed = 1'b0;
      end else begin
        rv_cnt--;
        if (br_eff) pend_killed = 1'b1;
      end
    end else if (req_now) begin
      if (gnt_cnt > 0) begin
        gnt_cnt--;
      end else begin
        imem.imem_gnt_i = 1'b1;
        pend_addr   = exp_pc;
        pending     = 1'b1;
        pend_killed = br_eff;
        rv_cnt      = rnd_on ? int'($urandom_range(0, 2)) : rv_delay;
        if (rnd_on) gnt_cnt = int'($urandom_range(0, 2));
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (br_eff) exp_pc = tgt & ~32'd3;
    imem.imem_rdata_i = rd;
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = tgt;
    st_prev = st;
    br_prev = br;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    imem.imem_gnt_i = 1'b0; imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'b0, imem.imem_req_o}, 32'd0);
    check_eq("rst_addr", imem.imem_addr_o, 32'h0);
    check_eq("rst_instr", instr_o, NOP_INSTR);
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_pc_incr", pc_incr_o, 32'h0);
    check_eq("rst_valid", {31'b0, valid_o}, 32'd0);
    rst_n = 1'b1;
    #1 check_eq("req_after_rst", {31'b0, imem.imem_req_o}, 32'd1);

    // Zero-wait fetch of 0, then stall over the response for PC 4
    idle(3);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0);
    // Grant withheld three cycles at PC 8
    gnt_cnt = 3;
    idle(7);

    // Redirect to 0x100 while a slow response is outstanding
    rv_delay = 2;
    for (int i = 0; i < 6 && !pending; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b0);
    idle(8);
    rv_delay = 0;

    // Redirect near the top of the address space to exercise wrap-around
    for (int i = 0; i < 6 && (pending || held); i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    idle(8);

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    cycle(1'b1, 32'h0000_0102, 1'b0);
    idle(6);
`endif

    // Random stall / redirect / memory latency traffic
    rnd_on = 1'b1;
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) == 0));
    rnd_on = 1'b0;
    gnt_cnt = 0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
